// File: rtl/ml_decision_collector_if.sv
// ml_decision_collector_if
//   Decision handshake between the ML decision collector and the output stage.
//   o_valid : decision available (producer -> consumer)
//   i_ready : consumer accepts the decision (consumer -> producer)
//   o_idx   : index of the minimum-metric candidate
//   o_min   : minimum metric of the frame
//   o_min2  : second-smallest metric (only when ML_SECOND_MIN_EN is defined)
//   Modports: master = collector side, slave = output-stage side.
interface ml_decision_collector_if #(
    parameter int unsigned METRIC_WIDTH = 24
);
    logic                    o_valid;
    logic                    i_ready;
    logic [4:0]              o_idx;
    logic [METRIC_WIDTH-1:0] o_min;
`ifdef ML_SECOND_MIN_EN
    logic [METRIC_WIDTH-1:0] o_min2;
`endif

    modport master (
        output o_valid,
        output o_idx,
        output o_min,
`ifdef ML_SECOND_MIN_EN
        output o_min2,
`endif
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_idx,
        input  o_min,
`ifdef ML_SECOND_MIN_EN
        input  o_min2,
`endif
        output i_ready
    );
endinterface

// File: rtl/ml_decision_collector.sv
// ml_decision_collector
//   Collects one (index, metric) pair per candidate from the compute unit, tracks the
//   minimum metric and its index over a NUM_CAND-candidate frame, flags duplicate or
//   missing indices, and offers the hard decision over a valid/ready handshake.
//   Optional macro ML_SECOND_MIN_EN adds the second-smallest metric (dec.o_min2).
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_cu_en        : metric-valid strobe
//   i_cnt          : candidate index; bit 5 marks the sweep terminator (ignored)
//   i_metric       : distance metric for i_cnt
//   dec            : decision handshake (o_valid, i_ready, o_idx, o_min[, o_min2])
//   o_busy         : frame in progress or decision held
//   o_dup_err      : sticky duplicate/missing index flag
//   o_drop_err     : sticky flag for a metric that arrived while holding a decision
module ml_decision_collector #(
    parameter int unsigned METRIC_WIDTH = 24,
    parameter int unsigned NUM_CAND     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cu_en,
    input  logic [5:0]              i_cnt,
    input  logic [METRIC_WIDTH-1:0] i_metric,
    ml_decision_collector_if.master dec,
    output logic                    o_busy,
    output logic                    o_dup_err,
    output logic                    o_drop_err
);
    localparam int unsigned IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CAND) + 1;
    localparam logic [METRIC_WIDTH-1:0] MetOnes = '1;

    typedef logic [NUM_CAND-1:0] mask_t;
    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_t;

    state_t                  state_q, state_d;
    logic [METRIC_WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    mask_t                   mask_q, mask_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dup_q, dup_d;
    logic                    drop_q, drop_d;
`ifdef ML_SECOND_MIN_EN
    logic [METRIC_WIDTH-1:0] min2_q, min2_d;
`endif

    logic             accept;
    logic [IDX_W-1:0] idx_in;
    mask_t            onehot;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        drop_d  = drop_q;
`ifdef ML_SECOND_MIN_EN
        min2_d  = min2_q;
`endif
        // Terminator (bit 5) is never a real candidate.
        accept = i_cu_en & ~i_cnt[5];
        idx_in = i_cnt[IDX_W-1:0];
        onehot = mask_t'(1) << idx_in;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAcc;
                    min_d   = i_metric;
                    idx_d   = idx_in;
                    mask_d  = onehot;
                    cnt_d   = CNT_W'(1);
`ifdef ML_SECOND_MIN_EN
                    min2_d  = MetOnes;
`endif
                end
            end
            StAcc: begin
                if (accept) begin
                    // Strict compare: ties keep the earlier index.
                    if (i_metric < min_q) begin
                        min_d  = i_metric;
                        idx_d  = idx_in;
`ifdef ML_SECOND_MIN_EN
                        min2_d = min_q;
                    end else if (i_metric < min2_q) begin
                        min2_d = i_metric;
`endif
                    end
                    if ((mask_q & onehot) != '0) begin
                        dup_d = 1'b1;
                    end
                    mask_d = mask_q | onehot;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                // Held decision is never disturbed by late samples.
                if (accept) begin
                    drop_d = 1'b1;
                end
                if (dec.i_ready) begin
                    state_d = StIdle;
                    min_d   = MetOnes;
                    idx_d   = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
`ifdef ML_SECOND_MIN_EN
                    min2_d  = MetOnes;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame completes on the cycle the last sample is accepted.
        if (state_q != StHold && accept && cnt_d == CNT_W'(NUM_CAND)) begin
            state_d = StHold;
            if (~&mask_d) begin
                dup_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            min_q   <= MetOnes;
            idx_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            drop_q  <= 1'b0;
`ifdef ML_SECOND_MIN_EN
            min2_q  <= MetOnes;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            drop_q  <= drop_d;
`ifdef ML_SECOND_MIN_EN
            min2_q  <= min2_d;
`endif
        end
    end

    assign dec.o_valid = (state_q == StHold);
    assign dec.o_idx   = 5'(idx_q);
    assign dec.o_min   = min_q;
`ifdef ML_SECOND_MIN_EN
    assign dec.o_min2  = min2_q;
`endif
    assign o_busy      = (state_q != StIdle);
    assign o_dup_err   = dup_q;
    assign o_drop_err  = drop_q;
endmodule

// File: tb/tb_ml_decision_collector.sv
// tb_ml_decision_collector
//   Scoreboarded bench for ml_decision_collector: each scenario builds a frame, a
//   reference model pushes the expected decision, and the decision is popped and
//   compared when the DUT raises o_valid.
module tb_ml_decision_collector;
    localparam logic [23:0] Ones = '1;

    typedef struct packed {
        logic [4:0]  idx;
        logic [23:0] min;
        logic [23:0] min2;
        logic        dup;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cu_en;
    logic [5:0]  cnt;
    logic [23:0] metric;
    logic        busy, dup_err, drop_err;
    logic [23:0] min2_obs;

    ml_decision_collector_if #(.METRIC_WIDTH(24)) dec_if ();

    ml_decision_collector #(
        .METRIC_WIDTH(24),
        .NUM_CAND    (32)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_cu_en   (cu_en),
        .i_cnt     (cnt),
        .i_metric  (metric),
        .dec       (dec_if.master),
        .o_busy    (busy),
        .o_dup_err (dup_err),
        .o_drop_err(drop_err)
    );

`ifdef ML_SECOND_MIN_EN
    assign min2_obs = dec_if.o_min2;
`else
    assign min2_obs = Ones;
`endif

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        e, obs;
    logic [5:0]  fr_idx[32];
    logic [23:0] fr_met[32];

    function automatic logic [5:0] gray(input int k);
        return 6'((k ^ (k >> 1)) & 31);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cu_en = 1'b0;
        dec_if.i_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [5:0] i, input logic [23:0] m);
        cu_en  = 1'b1;
        cnt    = i;
        metric = m;
        tick();
        cu_en  = 1'b0;
        cnt    = '0;
    endtask

    // Reference model of the frame decision.
    task automatic push_expected();
        exp_t        x;
        logic [31:0] mask;
        logic [4:0]  i;
        mask  = '0;
        x     = '0;
        for (int k = 0; k < 32; k++) begin
            i = fr_idx[k][4:0];
            if (k == 0) begin
                x.min = fr_met[k]; x.idx = i; x.min2 = Ones;
            end else if (fr_met[k] < x.min) begin
                x.min2 = x.min; x.min = fr_met[k]; x.idx = i;
            end else if (fr_met[k] < x.min2) begin
                x.min2 = fr_met[k];
            end
            if (mask[i]) x.dup = 1'b1;
            mask[i] = 1'b1;
        end
        if (mask != 32'hffff_ffff) x.dup = 1'b1;
`ifndef ML_SECOND_MIN_EN
        x.min2 = Ones;
`endif
        exp_q.push_back(x);
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cu_en = 1'b1; cnt = 6'd3; metric = 24'd5;
        dec_if.i_ready = 1'b0;
        tick(); tick();
        checks++;
        if (dec_if.o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: valid=%b busy=%b want 0 0", dec_if.o_valid, busy);
        end
        checks++;
        if (dec_if.o_idx !== 5'd0 || dec_if.o_min !== Ones || min2_obs !== Ones) begin
            errors++;
            $display("FAIL reset_data: idx=%0d min=%h min2=%h want 0 ffffff ffffff",
                     dec_if.o_idx, dec_if.o_min, min2_obs);
        end
        checks++;
        if (dup_err !== 1'b0 || drop_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: dup=%b drop=%b want 0 0", dup_err, drop_err);
        end
        reset = 1'b0;
        cu_en = 1'b0;
    endtask

    task automatic test_monotonic();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = gray(k); fr_met[k] = 24'(100 + k);
        end
        push_expected();
        for (int k = 0; k < 31; k++) send(fr_idx[k], fr_met[k]);
        checks++;
        if (dec_if.o_valid !== 1'b0) begin
            errors++; $display("FAIL mono_early_valid: valid=%b want 0", dec_if.o_valid);
        end
        send(fr_idx[31], fr_met[31]);
        checks++;
        if (dec_if.o_valid !== 1'b1) begin
            errors++; $display("FAIL mono_latency: valid=%b want 1", dec_if.o_valid);
        end
        pop_exp();
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (obs !== e || dec_if.o_min !== 24'd100 || dec_if.o_idx !== 5'd0) begin
            errors++; $display("FAIL mono_decision: got %h want %h", obs, e);
        end
        checks++;
        if (drop_err !== 1'b0) begin
            errors++; $display("FAIL mono_drop: drop=%b want 0", drop_err);
        end
        dec_if.i_ready = 1'b1;
        tick();
        dec_if.i_ready = 1'b0;
        checks++;
        if (dec_if.o_valid !== 1'b0 || busy !== 1'b0 || dec_if.o_min !== Ones) begin
            errors++;
            $display("FAIL mono_release: valid=%b busy=%b min=%h want 0 0 ffffff",
                     dec_if.o_valid, busy, dec_if.o_min);
        end
    endtask

    task automatic test_tie();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = 6'(k);
            fr_met[k] = (k == 17 || k == 22) ? 24'd20 : 24'd50;
        end
        push_expected();
        for (int k = 0; k < 32; k++) send(fr_idx[k], fr_met[k]);
        pop_exp();
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (dec_if.o_valid !== 1'b1 || obs !== e || dec_if.o_idx !== 5'd17) begin
            errors++;
            $display("FAIL tie_decision: valid=%b got %h want %h", dec_if.o_valid, obs, e);
        end
        dec_if.i_ready = 1'b1;
        tick();
        dec_if.i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = gray(k); fr_met[k] = 24'($urandom_range(1000, 5000));
        end
        push_expected();
        for (int k = 0; k < 32; k++) send(fr_idx[k], fr_met[k]);
        pop_exp();
        for (int c = 0; c < 10; c++) begin
            obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
            checks++;
            if (dec_if.o_valid !== 1'b1 || busy !== 1'b1 || obs !== e) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b busy=%b got %h want %h",
                         c, dec_if.o_valid, busy, obs, e);
            end
            tick();
        end
        send(6'd3, 24'd0);
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (drop_err !== 1'b1 || dec_if.o_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL bp_inject: drop=%b valid=%b got %h want 1 1 %h",
                     drop_err, dec_if.o_valid, obs, e);
        end
        // Release with a same-cycle sample: the sample must be dropped.
        dec_if.i_ready = 1'b1;
        send(6'd4, 24'd1);
        dec_if.i_ready = 1'b0;
        checks++;
        if (dec_if.o_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b drop=%b want 0 0 1",
                     dec_if.o_valid, busy, drop_err);
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = (k == 14) ? 6'd5 : gray(k);   // index 9 replaced by a second 5
            fr_met[k] = 24'(1000 - 3 * k);
        end
        push_expected();
        for (int k = 0; k < 14; k++) send(fr_idx[k], fr_met[k]);
        checks++;
        if (dup_err !== 1'b0) begin
            errors++; $display("FAIL dup_early: dup=%b want 0", dup_err);
        end
        send(fr_idx[14], fr_met[14]);
        checks++;
        if (dup_err !== 1'b1) begin
            errors++; $display("FAIL dup_second5: dup=%b want 1", dup_err);
        end
        for (int k = 15; k < 32; k++) send(fr_idx[k], fr_met[k]);
        pop_exp();
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (dec_if.o_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL dup_decision: valid=%b got %h want %h", dec_if.o_valid, obs, e);
        end
        dec_if.i_ready = 1'b1;
        tick();
        dec_if.i_ready = 1'b0;
    endtask

    task automatic test_gaps();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = gray(k); fr_met[k] = 24'($urandom_range(10, 900));
        end
        push_expected();
        for (int k = 0; k < 32; k++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            if (k == 10 || k == 31) send(6'd32, 24'd0);
            if (k == 31) begin
                checks++;
                if (dec_if.o_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_term_counted: valid=%b busy=%b want 0 1",
                             dec_if.o_valid, busy);
                end
            end
            send(fr_idx[k], fr_met[k]);
        end
        pop_exp();
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (dec_if.o_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL gap_decision: valid=%b got %h want %h", dec_if.o_valid, obs, e);
        end
        dec_if.i_ready = 1'b1;
        tick();
        dec_if.i_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int k = 0; k < 12; k++) send(gray(k), 24'(3 + k));
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_busy: busy=%b want 1", busy);
        end
        do_reset();
        checks++;
        if (dec_if.o_valid !== 1'b0 || busy !== 1'b0 || dec_if.o_idx !== 5'd0 ||
            dec_if.o_min !== Ones || min2_obs !== Ones || dup_err !== 1'b0 ||
            drop_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: valid=%b busy=%b idx=%0d min=%h dup=%b drop=%b",
                     dec_if.o_valid, busy, dec_if.o_idx, dec_if.o_min, dup_err, drop_err);
        end
        for (int k = 0; k < 32; k++) begin
            fr_idx[k] = gray(k);
            fr_met[k] = (gray(k) == 6'd30) ? 24'd7 : 24'(200 + k);
        end
        push_expected();
        for (int k = 0; k < 32; k++) send(fr_idx[k], fr_met[k]);
        pop_exp();
        obs = {dec_if.o_idx, dec_if.o_min, min2_obs, dup_err};
        checks++;
        if (dec_if.o_valid !== 1'b1 || obs !== e || dec_if.o_idx !== 5'd30 ||
            dec_if.o_min !== 24'd7) begin
            errors++;
            $display("FAIL rst_clean_decision: valid=%b got %h want %h", dec_if.o_valid, obs, e);
        end
        dec_if.i_ready = 1'b1;
        tick();
        dec_if.i_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cu_en = 1'b0;
        cnt = '0;
        metric = '0;
        dec_if.i_ready = 1'b0;
        test_reset();
        test_monotonic();
        test_tie();
        test_backpressure();
        test_duplicate();
        test_gaps();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
